controller_sequencer: RTL

- SAP-1 control unit that drives the program counter's `cp`/`ep` inputs and every other bus-control line.
- Contains a 6-state one-hot ring counter (T1..T6) and a microcode decoder keyed on the instruction-register opcode nibble.
- Issues one 12-bit control word per T-state and halts on HLT.
- Updates on the falling edge of `clk`, so control lines are stable before the rising edge where registers load.

---
 rtl/sap1_pkg.sv | 49 ++++
 rtl/controller_sequencer_ring_counter.sv | 23 ++
 rtl/controller_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: opcodes, microcode control words, control-word bit positions.
package sap1_pkg;

  localparam int unsigned RING_LEN = 6;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned CW_W     = 12;

  typedef logic [CW_W-1:0]  cw_t;
  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OPC_LDA = 4'b0000;
  localparam opc_t OPC_ADD = 4'b0001;
  localparam opc_t OPC_SUB = 4'b0010;
  localparam opc_t OPC_OUT = 4'b1110;
  localparam opc_t OPC_HLT = 4'b1111;

  // Control word order MSB first: cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n
  localparam int unsigned CW_CP   = 11;
  localparam int unsigned CW_EP   = 10;
  localparam int unsigned CW_LM_N = 9;
  localparam int unsigned CW_CE_N = 8;
  localparam int unsigned CW_LI_N = 7;
  localparam int unsigned CW_EI_N = 6;
  localparam int unsigned CW_LA_N = 5;
  localparam int unsigned CW_EA   = 4;
  localparam int unsigned CW_SU   = 3;
  localparam int unsigned CW_EU   = 2;
  localparam int unsigned CW_LB_N = 1;
  localparam int unsigned CW_LO_N = 0;

  localparam cw_t CW_NOP      = 12'h3E3;
  localparam cw_t CW_FETCH_T1 = 12'h5E3;
  localparam cw_t CW_FETCH_T2 = 12'hBE3;
  localparam cw_t CW_FETCH_T3 = 12'h263;

  localparam cw_t CW_LDA_T4 = 12'h1A3;
  localparam cw_t CW_LDA_T5 = 12'h2C3;
  localparam cw_t CW_LDA_T6 = 12'h3E3;
  localparam cw_t CW_ADD_T4 = 12'h1A3;
  localparam cw_t CW_ADD_T5 = 12'h2E1;
  localparam cw_t CW_ADD_T6 = 12'h3C7;
  localparam cw_t CW_SUB_T4 = 12'h1A3;
  localparam cw_t CW_SUB_T5 = 12'h2E1;
  localparam cw_t CW_SUB_T6 = 12'h3CF;
  localparam cw_t CW_OUT_T4 = 12'h3F2;
  localparam cw_t CW_OUT_T5 = 12'h3E3;
  localparam cw_t CW_OUT_T6 = 12'h3E3;

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring: sync clear to T1, rotates when enabled and not frozen (falling edge).
module ring_counter
  import sap1_pkg::*;
#(
  parameter int unsigned LEN = RING_LEN
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           en,
  input  logic           freeze,
  output logic [LEN-1:0] ring
);

  // Rotate one position toward the MSB; T6 wraps back to T1.
  always_ff @(negedge clk) begin
    if (clr) begin
      ring <= LEN'(1);
    end else if (en && !freeze) begin
      ring <= {ring[LEN-2:0], ring[LEN-1]};
    end
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: T-state ring plus microcode decoder, falling-edge timed.
// Optional build macro SINGLE_STEP_EN adds the step input that gates ring advance.
module controller_sequencer
  import sap1_pkg::*;
#(
  parameter int unsigned RING_LEN = sap1_pkg::RING_LEN,
  parameter int unsigned OPC_W    = sap1_pkg::OPC_W
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [OPC_W-1:0]    opcode,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                cp,
  output logic                ep,
  output logic                lm_n,
  output logic                ce_n,
  output logic                li_n,
  output logic                ei_n,
  output logic                la_n,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                lb_n,
  output logic                lo_n,
  output logic                hlt,
  output logic [RING_LEN-1:0] t_state
);

  logic run_q, run_d;
  logic hlt_q, hlt_d;
  logic step_ok;
  logic adv;
  cw_t  cw;

`ifdef SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // The first edge after clr only arms the sequencer; later edges advance it.
  assign adv = run_q && step_ok && !hlt_q;

  ring_counter #(.LEN(RING_LEN)) u_ring (
    .clk    (clk),
    .clr    (clr),
    .en     (adv),
    .freeze (hlt_q),
    .ring   (t_state)
  );

  // State register: armed and halted flags.
  always_ff @(negedge clk) begin
    if (clr) begin
      run_q <= 1'b0;
      hlt_q <= 1'b0;
    end else begin
      run_q <= run_d;
      hlt_q <= hlt_d;
    end
  end

  // Next state: arm after clr release; latch halt when entering T4 with HLT.
  always_comb begin
    run_d = 1'b1;
    hlt_d = hlt_q;
    if (adv && t_state[2] && (opcode == OPC_HLT)) begin
      hlt_d = 1'b1;
    end
  end

  // Output decode: NOP while clearing, before arming, or halted; else microcode by T-state.
  always_comb begin
    cw = CW_NOP;
    if (!clr && run_q && !hlt_q) begin
      if (t_state[0]) begin
        cw = CW_FETCH_T1;
      end else if (t_state[1]) begin
        cw = CW_FETCH_T2;
      end else if (t_state[2]) begin
        cw = CW_FETCH_T3;
      end else if (t_state[3]) begin
        case (opcode)
          OPC_LDA: cw = CW_LDA_T4;
          OPC_ADD: cw = CW_ADD_T4;
          OPC_SUB: cw = CW_SUB_T4;
          OPC_OUT: cw = CW_OUT_T4;
          default: cw = CW_NOP;
        endcase
      end else if (t_state[4]) begin
        case (opcode)
          OPC_LDA: cw = CW_LDA_T5;
          OPC_ADD: cw = CW_ADD_T5;
          OPC_SUB: cw = CW_SUB_T5;
          OPC_OUT: cw = CW_OUT_T5;
          default: cw = CW_NOP;
        endcase
      end else if (t_state[5]) begin
        case (opcode)
          OPC_LDA: cw = CW_LDA_T6;
          OPC_ADD: cw = CW_ADD_T6;
          OPC_SUB: cw = CW_SUB_T6;
          OPC_OUT: cw = CW_OUT_T6;
          default: cw = CW_NOP;
        endcase
      end
    end
  end

  assign cp   = cw[CW_CP];
  assign ep   = cw[CW_EP];
  assign lm_n = cw[CW_LM_N];
  assign ce_n = cw[CW_CE_N];
  assign li_n = cw[CW_LI_N];
  assign ei_n = cw[CW_EI_N];
  assign la_n = cw[CW_LA_N];
  assign ea   = cw[CW_EA];
  assign su   = cw[CW_SU];
  assign eu   = cw[CW_EU];
  assign lb_n = cw[CW_LB_N];
  assign lo_n = cw[CW_LO_N];
  assign hlt  = hlt_q;

endmodule
